// File: rtl/edge_trigger_bank.sv
// rtl/edge_trigger_bank.sv - multi-channel synchronised edge trigger with pulse and hold-off
// Optional saturating per-channel event counters: define EDGE_TRIG_COUNT_EN.
module edge_trigger_bank #(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int PULSE_W     = 1,
   parameter int HOLDOFF     = 8,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       start,
   input  logic [2*N_CH-1:0]     mode,
`ifdef EDGE_TRIG_COUNT_EN
   input  logic                  cnt_clr,
   output logic [N_CH*CNT_W-1:0] evt_cnt,
`endif
   output logic [N_CH-1:0]       trigger,
   output logic [N_CH-1:0]       busy
);

   localparam int HO_EFF    = (HOLDOFF > PULSE_W) ? HOLDOFF : PULSE_W;
   localparam bit HAS_HOLD  = (HOLDOFF > PULSE_W);
   localparam int CW        = (HO_EFF > 1) ? $clog2(HO_EFF) : 1;
   localparam int HOLD_LOAD = HAS_HOLD ? (HOLDOFF - PULSE_W - 1) : 0;
   localparam int WW        = $clog2(SYNC_STAGES + 2);

   typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

   // Detection stays masked until the synchronisers and p hold post-reset levels.
   logic [WW-1:0] warm_q;
   logic          armed;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         warm_q <= WW'(SYNC_STAGES + 1);
      else if (warm_q != '0)
         warm_q <= warm_q - 1'b1;
   end

   assign armed = (warm_q == '0);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   p_q;
      logic                   s, rise, fall, off, hit, done, accept;
      logic [1:0]             m;
      state_t                 state_q;
      logic [CW-1:0]          cnt_q;
      logic                   trig_q, busy_q;

      assign m    = mode[2*i +: 2];
      assign s    = sync_q[SYNC_STAGES-1];
      assign rise = s & ~p_q;
      assign fall = ~s & p_q;
      assign off  = (m == 2'b00);
      assign hit  = armed & ((m[0] & rise) | (m[1] & fall));

      // The last busy cycle may accept a new edge so triggers can repeat every HO_EFF cycles.
      assign done   = ((state_q == PULSE) && (cnt_q == '0) && !HAS_HOLD) ||
                      ((state_q == HOLD) && (cnt_q == '0));
      assign accept = hit & ((state_q == IDLE) | done);

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sync_q <= '0;
            p_q    <= 1'b0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], start[i]};
            p_q    <= s;
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
         end else if (off) begin
            state_q <= IDLE;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
         end else if (accept) begin
            state_q <= PULSE;
            cnt_q   <= CW'(PULSE_W - 1);
            trig_q  <= 1'b1;
            busy_q  <= 1'b1;
         end else begin
            case (state_q)
               PULSE: begin
                  if (cnt_q != '0) begin
                     cnt_q <= cnt_q - 1'b1;
                  end else if (HAS_HOLD) begin
                     state_q <= HOLD;
                     cnt_q   <= CW'(HOLD_LOAD);
                     trig_q  <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                     trig_q  <= 1'b0;
                     busy_q  <= 1'b0;
                  end
               end
               HOLD: begin
                  if (cnt_q != '0) begin
                     cnt_q <= cnt_q - 1'b1;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end

      assign trigger[i] = trig_q;
      assign busy[i]    = busy_q;

`ifdef EDGE_TRIG_COUNT_EN
      logic [CNT_W-1:0] evt_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst)
            evt_q <= '0;
         else if (cnt_clr)
            evt_q <= '0;
         else if (accept && (evt_q != '1))
            evt_q <= evt_q + 1'b1;
      end

      assign evt_cnt[CNT_W*i +: CNT_W] = evt_q;
`endif
   end

endmodule

// File: tb/tb_edge_trigger_bank.sv
// tb/tb_edge_trigger_bank.sv - directed and random bench for edge_trigger_bank
// Reference model works on absolute cycle numbers and a sampled-input history.
module tb_edge_trigger_bank;
   localparam int N_CH        = 4;
   localparam int SYNC_STAGES = 2;
   localparam int PULSE_W     = 3;
   localparam int HOLDOFF     = 8;
   localparam int CNT_W       = 4;
   localparam int HO_EFF      = (HOLDOFF > PULSE_W) ? HOLDOFF : PULSE_W;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [N_CH-1:0]       start_r;
   logic [2*N_CH-1:0]     mode_r;
   logic                  clr_r;
   logic [N_CH-1:0]       trigger, busy;
`ifdef EDGE_TRIG_COUNT_EN
   logic [N_CH*CNT_W-1:0] evt_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int e = 0;
   logic [N_CH-1:0] hist [0:4095];
   int end_trig [N_CH];
   int end_busy [N_CH];
   int exp_cnt  [N_CH];
   int rise_cnt [N_CH];
   int high_cnt [N_CH];
   logic [N_CH-1:0] exp_trig, exp_busy, prev_trig;

   edge_trigger_bank #(
      .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .PULSE_W(PULSE_W),
      .HOLDOFF(HOLDOFF), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start_r),
      .mode(mode_r),
`ifdef EDGE_TRIG_COUNT_EN
      .cnt_clr(clr_r),
      .evt_cnt(evt_cnt),
`endif
      .trigger(trigger),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      e = 0;
      prev_trig = '0;
      for (int c = 0; c < N_CH; c++) begin
         end_trig[c] = 0;
         end_busy[c] = 0;
         exp_cnt[c]  = 0;
      end
   endtask

   task automatic clr_counts();
      for (int c = 0; c < N_CH; c++) begin
         rise_cnt[c] = 0;
         high_cnt[c] = 0;
      end
   endtask

   // One clock: the edge number e sees the inputs held since the previous step.
   task automatic step();
      logic [N_CH-1:0] s_now, p_now;
`ifdef EDGE_TRIG_COUNT_EN
      logic [N_CH*CNT_W-1:0] ev;
`endif
      @(posedge clk);
      e++;
      hist[e] = start_r;
      s_now = (e - SYNC_STAGES >= 1) ? hist[e-SYNC_STAGES] : '0;
      p_now = (e - SYNC_STAGES - 1 >= 1) ? hist[e-SYNC_STAGES-1] : '0;
      for (int c = 0; c < N_CH; c++) begin
         logic [1:0] m;
         logic       hit;
         m   = mode_r[2*c +: 2];
         hit = (m[0] && s_now[c] && !p_now[c]) || (m[1] && !s_now[c] && p_now[c]);
         if (m == 2'b00) begin
            end_trig[c] = e;
            end_busy[c] = e;
         end else if (hit && e >= SYNC_STAGES + 2 && e >= end_busy[c]) begin
            end_trig[c] = e + PULSE_W;
            end_busy[c] = e + HO_EFF;
            if (exp_cnt[c] < 2**CNT_W - 1) exp_cnt[c]++;
         end
         if (clr_r) exp_cnt[c] = 0;
         exp_trig[c] = (e < end_trig[c]);
         exp_busy[c] = (e < end_busy[c]);
      end
      #1;
      chk("trigger", trigger, exp_trig);
      chk("busy", busy, exp_busy);
`ifdef EDGE_TRIG_COUNT_EN
      for (int c = 0; c < N_CH; c++) ev[CNT_W*c +: CNT_W] = CNT_W'(exp_cnt[c]);
      chk("evt_cnt", evt_cnt, ev);
`endif
      for (int c = 0; c < N_CH; c++) begin
         rise_cnt[c] += int'(trigger[c] & ~prev_trig[c]);
         high_cnt[c] += int'(trigger[c]);
      end
      prev_trig = trigger;
   endtask

   initial begin
      rst     = 1'b0;
      start_r = 4'b0001;
      mode_r  = 8'h55;
      clr_r   = 1'b0;
      model_reset();
      clr_counts();

      // Reset state, with start[0] high through release.
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("rst_trigger", trigger, 0);
         chk("rst_busy", busy, 0);
`ifdef EDGE_TRIG_COUNT_EN
         chk("rst_evt", evt_cnt, 0);
`endif
      end
      rst = 1'b1;
      model_reset();
      repeat (20) step();
      chk("warmup_no_trigger", rise_cnt[0], 0);

      // Latency and pulse width.
      start_r[0] = 1'b0;
      repeat (5) step();
      start_r[0] = 1'b1;
      step();
      step();
      chk("latency_k1", trigger[0], 0);
      step();
      chk("latency_k2", trigger[0], 1);
      step();
      step();
      chk("pulse_last", trigger[0], 1);
      step();
      chk("pulse_end", trigger[0], 0);

      // Edge modes: ch1 fall, ch2 both, ch3 off.
      mode_r = 8'b00_11_10_01;
      repeat (12) step();
      clr_counts();
      start_r[3:1] = 3'b111;
      repeat (20) step();
      start_r[3:1] = 3'b000;
      repeat (20) step();
      chk("fall_mode_count", rise_cnt[1], 1);
      chk("both_mode_count", rise_cnt[2], 2);
      chk("off_mode_count", rise_cnt[3], 0);

      // Hold-off: captures at 0, 4, 9.
      mode_r  = 8'h55;
      start_r = '0;
      repeat (12) step();
      clr_counts();
      for (int c = 0; c < 30; c++) begin
         start_r[0] = (c < 2) || (c >= 4 && c < 6) || (c >= 9 && c < 11);
         step();
      end
      chk("holdoff_triggers", rise_cnt[0], 2);
      chk("holdoff_high_cycles", high_cnt[0], 2 * PULSE_W);

      // Simultaneous edges, then abort ch0 mid-pulse.
      start_r = '0;
      repeat (12) step();
      start_r = 4'hF;
      for (int i = 0; i < 10 && trigger == '0; i++) step();
      chk("simultaneous", trigger, 4'hF);
      mode_r[1:0] = 2'b00;
      step();
      chk("abort_trigger", trigger, 4'hE);
      chk("abort_busy0", busy[0], 0);
      mode_r[1:0] = 2'b01;
      start_r = '0;
      repeat (12) step();

`ifdef EDGE_TRIG_COUNT_EN
      clr_r = 1'b1;
      step();
      clr_r = 1'b0;
      repeat (17) begin
         start_r[0] = 1'b1;
         repeat (4) step();
         start_r[0] = 1'b0;
         repeat (6) step();
      end
      repeat (10) step();
      chk("evt_saturated", evt_cnt[CNT_W-1:0], 15);
      start_r[0] = 1'b1;
      step();
      step();
      clr_r = 1'b1;
      step();
      clr_r = 1'b0;
      chk("clr_vs_inc_trigger", trigger[0], 1);
      chk("clr_vs_inc_count", evt_cnt[CNT_W-1:0], 0);
      start_r[0] = 1'b0;
      repeat (10) step();
`endif

      // Random levels, occasional mode changes and clears.
      repeat (800) begin
         int ch;
         for (int c = 0; c < N_CH; c++)
            if ($urandom_range(3) == 0) start_r[c] = ~start_r[c];
         if ($urandom_range(39) == 0) begin
            ch = $urandom_range(N_CH - 1);
            mode_r[2*ch +: 2] = 2'($urandom_range(3));
         end
         clr_r = ($urandom_range(49) == 0);
         step();
      end
      clr_r = 1'b0;

      // Asynchronous reset during a pulse.
      mode_r  = 8'h55;
      start_r = '0;
      repeat (12) step();
      start_r[0] = 1'b1;
      repeat (3) step();
      chk("pre_reset_trigger", trigger[0], 1);
      rst = 1'b0;
      #2;
      chk("async_rst_trigger", trigger, 0);
      chk("async_rst_busy", busy, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (12) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/edge_trigger_bank.md
# edge_trigger_bank

Parametrised multi-channel trigger generator for the real-time feedback path. Each channel synchronises an asynchronous start level, detects a selectable edge, and emits a fixed-width trigger pulse followed by a programmable hold-off dead time. It replaces single-channel rising-edge pulse formers wherever several triggers share one clock domain.

## Interface
- `N_CH`, 4: number of independent channels, 1–32
- `SYNC_STAGES`, 2: synchroniser flops per channel, 2–4
- `PULSE_W`, 1: trigger pulse width in clk cycles, ≥1
- `HOLDOFF`, 8: dead time in cycles, counted from the first pulse cycle; values below PULSE_W behave as PULSE_W
- `CNT_W`, 16: event counter width; used only with the macro
- `clk`  input  1  system clock; all logic on the rising edge
- `rst`  input  1  asynchronous, active-low reset
- `start`  input  N_CH  asynchronous start levels, one bit per channel
- `mode`  input  2·N_CH  per-channel edge select; bits [2i+1:2i] for channel i; 00 = off, 01 = rise, 10 = fall, 11 = both
- `trigger`  output  N_CH  registered trigger pulses
- `busy`  output  N_CH  channel is in PULSE or HOLD
- `cnt_clr`  input  1  synchronous clear of all event counters (macro only)
- `evt_cnt`  output  N_CH·CNT_W  per-channel accepted-trigger counts; channel i occupies [CNT_W·(i+1)-1 : CNT_W·i] (macro only)

## Operation
- Per channel: a SYNC_STAGES flop chain feeds `s`. Register `p` holds the previous `s`.
- rise = s & ~p; fall = ~s & p. An edge is qualified by the channel's `mode`.
- Per-channel FSM:
  - IDLE: on a qualified edge, go to PULSE and load the cycle counter.
  - PULSE: `trigger` is high for exactly PULSE_W cycles, then go to HOLD. If HOLDOFF ≤ PULSE_W, go to IDLE instead.
  - HOLD: stay for HOLDOFF − PULSE_W cycles, then go to IDLE.
  - Edges seen in PULSE or HOLD are discarded, not queued.
- Warm-up: after reset release, detection is masked for SYNC_STAGES+1 cycles. Input levels present at reset therefore never produce a trigger.
- Mode change:
  - Mode 00 forces IDLE on the next edge and drops `trigger`/`busy`.
  - Any other change affects only future detections; an in-progress pulse or hold-off completes.
- Channels are fully independent. Simultaneous edges on several channels all trigger in the same cycle.
- Reset values: all sync flops, `p`, `trigger`, `busy` and `evt_cnt` are 0; all FSMs are in IDLE; warm-up counter is loaded.
- Reset asserted mid-pulse clears `trigger` immediately, asynchronously.

## Timing
- Latency: the input transition is captured at clk edge k; `trigger` rises after edge k+SYNC_STAGES. With the default, that is 2 cycles.
- `trigger` is a registered output: no combinational path from `start` or `mode`.
- Minimum spacing between accepted triggers on one channel is max(HOLDOFF, PULSE_W) cycles.
- An input pulse shorter than one clk period may be missed. This is not an error.
- In both-edge mode, an input toggling every cycle yields one trigger per hold-off window.

## Configuration
- `EDGE_TRIG_COUNT_EN` defined:
  - Each channel has a CNT_W-bit counter that increments on every IDLE→PULSE transition.
  - The counter saturates at all-ones; it does not wrap.
  - `cnt_clr` zeroes all counters on the next edge. If a clear and an increment happen in the same cycle, the clear wins and the result is 0.
- Macro undefined: `cnt_clr` and `evt_cnt` ports are absent and no counter logic exists.

## Test plan
- Reset behaviour: N_CH=4, mode=01 on all channels, start[0] held high through reset release → no trigger during or after warm-up. A later 0→1 on start[0] gives trigger[0] high 2 cycles after capture, for PULSE_W cycles.
- Edge modes: ch1 in mode 10, ch2 in mode 11, ch3 in mode 00; drive 0→1→0 on each with 20-cycle spacing → ch1 fires once, on the fall; ch2 fires twice; ch3 never fires; busy mirrors each FSM.
- Hold-off: PULSE_W=3, HOLDOFF=8; rising edges on ch0 at cycles 0, 4 and 9 → triggers for the edges at 0 and 9 only; the edge at 4 is discarded.
- Simultaneous edges and abort: rising edge on all 4 channels in one cycle → all triggers rise in the same cycle. Setting mode[1:0]=00 mid-pulse → trigger[0] low on the next cycle.
- Counters (macro on, CNT_W=4): 17 accepted triggers on ch0 → evt_cnt ch0 = 15 (saturated). A `cnt_clr` in the same cycle as a new trigger → count = 0.
- Asynchronous reset: assert `rst` low during PULSE → trigger and busy go to 0 without waiting for a clk edge.
